mat_stream_tx: RTL and testbench

MAT_STREAM_TX -- requirements
Module: mat_stream_tx

---
 rtl/mm_pkg.sv | 14 +
 rtl/mat_stream_tx_if.sv | 16 +
 rtl/axis_skid2.sv | 68 ++++++
 rtl/mat_stream_tx.sv | 138 +++++++++++++
 tb/tb_mat_stream_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared types and widths for the matrix streaming blocks.
// Beats are 32-bit words carrying four packed matrix elements.
package mm_pkg;

  localparam int AXIS_W = 32;
  localparam int KEEP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/mat_stream_tx_if.sv
// AXI-Stream style beat bus used by the matrix transmitter.
// The transmitter drives the master side; the sink drives tready.
interface mat_stream_tx_if
  import mm_pkg::*;
  ;

  logic [AXIS_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_skid2.sv
// Two-entry ready/valid buffer with registered outputs.
// The head entry feeds the output directly, so it holds still while stalled.
module axis_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         push, pop;

  assign in_ready  = (occ_q != 2'd2) || out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = occ_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop keeps the count; the new word joins behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/mat_stream_tx.sv
// Reads a run of 32-bit words from a BRAM and streams them out as beats.
// Reads are throttled so the 2-entry output buffer can never overflow.
module mat_stream_tx
  import mm_pkg::*;
#(
  parameter  int D_W          = 8,
  parameter  int MATRIXSIZE_W = 16,
  parameter  int MEM_DEPTH    = 4096,
  localparam int ADDR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [MATRIXSIZE_W-1:0] num_words,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [AXIS_W-1:0]       rd_data,
  mat_stream_tx_if.master         m_axis,
  output logic                    busy,
  output logic                    done
);

  tx_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [MATRIXSIZE_W-1:0] num_words_q, num_words_d;
  logic [MATRIXSIZE_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [MATRIXSIZE_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                    inflight_q, inflight_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    skid_in_ready;
  logic                    skid_valid;
  logic [AXIS_W-1:0]       skid_data;
  logic [1:0]              skid_occ;
  logic [AXIS_W-1:0]       lane_data;
  logic                    tlast;
  logic                    beat_fire;
  logic                    last_read;
  logic [2:0]              credit_used;

  axis_skid2 #(.W(AXIS_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_ready  (skid_in_ready),
    .in_data   (rd_data),
    .out_valid (skid_valid),
    .out_ready (m_axis.tready),
    .out_data  (skid_data),
    .occupancy (skid_occ)
  );

  // Buffer slots still spoken for after this cycle's pop, including the read already in flight.
  assign beat_fire   = skid_valid && m_axis.tready;
  assign credit_used = {1'b0, skid_occ} - {2'b00, beat_fire} + {2'b00, inflight_q};
  assign rd_en       = (state_q == ST_RUN) && (credit_used < 3'd2) && skid_in_ready;
  assign rd_addr     = addr_q;
  assign last_read   = (rd_cnt_q == num_words_q - MATRIXSIZE_W'(1));
  assign tlast       = skid_valid && (beat_cnt_q == num_words_q - MATRIXSIZE_W'(1));

  always_comb begin
    lane_data = '0;
    for (int e = 0; e < KEEP_W; e++) begin
      lane_data[e*D_W +: D_W] = skid_data[e*D_W +: D_W];
    end
  end

  assign m_axis.tdata  = lane_data;
  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = tlast;
  assign m_axis.tvalid = skid_valid;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_words_d = num_words_q;
    rd_cnt_d    = rd_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    inflight_d  = rd_en;
    if (beat_fire) beat_cnt_d = beat_cnt_q + MATRIXSIZE_W'(1);
    case (state_q)
      ST_IDLE: begin
        // The done cycle is still part of the previous transfer, so a start there is dropped.
        if (start && !done_q) begin
          addr_d      = base_addr;
          num_words_d = num_words;
          rd_cnt_d    = '0;
          beat_cnt_d  = '0;
          if (num_words != '0) state_d = ST_RUN;
          else                 done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          addr_d   = addr_q + ADDR_W'(1);
          rd_cnt_d = rd_cnt_q + MATRIXSIZE_W'(1);
          if (last_read) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (beat_fire && tlast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      num_words_q <= '0;
      rd_cnt_q    <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_words_q <= num_words_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_mat_stream_tx.sv
// Directed testbench for mat_stream_tx; the BRAM model returns word k = k.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_mat_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [15:0] num_words;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  int          checks = 0;
  int          errors = 0;

  mat_stream_tx_if axis ();

  mat_stream_tx #(.D_W(8), .MATRIXSIZE_W(16), .MEM_DEPTH(4096)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_axis    (axis),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= {20'd0, rd_addr};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; axis.tready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b expected 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b expected 0", axis.tlast); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %b expected 0", rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (axis.tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata got %h expected 0", axis.tdata); end
    checks++; if (axis.tkeep !== 4'hF) begin errors++; $display("[TB] FAIL reset_tkeep got %h expected f", axis.tkeep); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [8:0] e_rd, e_tv, e_tl, e_dn, e_bz;
    e_rd = 9'b000011110; e_tv = 9'b001111000; e_tl = 9'b001000000;
    e_dn = 9'b010000000; e_bz = 9'b011111110;
    idle(2);
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      start = (c == 0);
      base_addr = (c == 0) ? 12'd0 : 12'd7;
      num_words = (c == 0) ? 16'd4 : 16'd99;
      @(negedge clk);
      checks++; if (rd_en !== e_rd[c]) begin errors++; $display("[TB] FAIL basic_rd_en c=%0d got %b expected %b", c, rd_en, e_rd[c]); end
      checks++; if (axis.tvalid !== e_tv[c]) begin errors++; $display("[TB] FAIL basic_tvalid c=%0d got %b expected %b", c, axis.tvalid, e_tv[c]); end
      checks++; if (axis.tlast !== e_tl[c]) begin errors++; $display("[TB] FAIL basic_tlast c=%0d got %b expected %b", c, axis.tlast, e_tl[c]); end
      checks++; if (done !== e_dn[c]) begin errors++; $display("[TB] FAIL basic_done c=%0d got %b expected %b", c, done, e_dn[c]); end
      checks++; if (busy !== e_bz[c]) begin errors++; $display("[TB] FAIL basic_busy c=%0d got %b expected %b", c, busy, e_bz[c]); end
      if (e_rd[c]) begin
        checks++; if (rd_addr !== 12'(c - 1)) begin errors++; $display("[TB] FAIL basic_rd_addr c=%0d got %0d expected %0d", c, rd_addr, c - 1); end
      end
      if (e_tv[c]) begin
        checks++; if (axis.tdata !== 32'(c - 3)) begin errors++; $display("[TB] FAIL basic_tdata c=%0d got %0d expected %0d", c, axis.tdata, c - 3); end
        checks++; if (axis.tkeep !== 4'hF) begin errors++; $display("[TB] FAIL basic_tkeep c=%0d got %h expected f", c, axis.tkeep); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0]  pat;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall, done_seen;
    int          beats;
    pat = 4'b1001; prev_stall = 0; done_seen = 0; beats = 0; prev_data = '0; prev_last = 1'b0;
    idle(2);
    for (int c = 0; c < 80 && !done_seen; c++) begin
      next_cycle();
      start = (c == 0); base_addr = 12'd16; num_words = 16'd8;
      axis.tready = pat[c[1:0]];
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, prev_last, prev_data}) begin
          errors++; $display("[TB] FAIL stall_hold c=%0d got v=%b l=%b d=%0d expected v=1 l=%b d=%0d", c, axis.tvalid, axis.tlast, axis.tdata, prev_last, prev_data);
        end
      end
      if (axis.tvalid && axis.tready) begin
        checks++; if (axis.tdata !== 32'(16 + beats)) begin errors++; $display("[TB] FAIL stall_data beat=%0d got %0d expected %0d", beats, axis.tdata, 16 + beats); end
        checks++; if (axis.tlast !== (beats == 7)) begin errors++; $display("[TB] FAIL stall_tlast beat=%0d got %b expected %b", beats, axis.tlast, beats == 7); end
        beats++;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      if (done) done_seen = 1;
    end
    checks++; if (beats != 8) begin errors++; $display("[TB] FAIL stall_count got %0d expected 8", beats); end
    checks++; if (!done_seen) begin errors++; $display("[TB] FAIL stall_done got 0 expected 1"); end
    start = 1'b0; axis.tready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [4];
    int reads, beats;
    bit done_seen;
    exp_a = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    reads = 0; beats = 0; done_seen = 0;
    idle(2);
    for (int c = 0; c < 20 && !done_seen; c++) begin
      next_cycle();
      start = (c == 0); base_addr = 12'd4094; num_words = 16'd4;
      @(negedge clk);
      if (rd_en) begin
        checks++; if (reads >= 4 || rd_addr !== exp_a[reads]) begin errors++; $display("[TB] FAIL wrap_addr read=%0d got %0d expected %0d", reads, rd_addr, exp_a[reads]); end
        reads++;
      end
      if (axis.tvalid && axis.tready) begin
        checks++; if (beats >= 4 || axis.tdata !== {20'd0, exp_a[beats]}) begin errors++; $display("[TB] FAIL wrap_data beat=%0d got %0d expected %0d", beats, axis.tdata, exp_a[beats]); end
        beats++;
      end
      if (done) done_seen = 1;
    end
    checks++; if (reads != 4) begin errors++; $display("[TB] FAIL wrap_reads got %0d expected 4", reads); end
    checks++; if (beats != 4) begin errors++; $display("[TB] FAIL wrap_beats got %0d expected 4", beats); end
    start = 1'b0;
  endtask

  task automatic test_zero();
    idle(2);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      start = (c == 0) || (c == 1);
      num_words = (c == 0) ? 16'd0 : 16'd3;
      base_addr = 12'd50;
      @(negedge clk);
      checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL zero_rd_en c=%0d got %b expected 0", c, rd_en); end
      checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL zero_tvalid c=%0d got %b expected 0", c, axis.tvalid); end
      checks++; if (done !== (c == 1)) begin errors++; $display("[TB] FAIL zero_done c=%0d got %b expected %b", c, done, c == 1); end
      checks++; if (busy !== (c == 1)) begin errors++; $display("[TB] FAIL zero_busy c=%0d got %b expected %b", c, busy, c == 1); end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    idle(2);
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      start = (c == 0) || (c == 7);
      rst   = (c == 6);
      base_addr = (c < 7) ? 12'd0 : 12'd40;
      num_words = (c < 7) ? 16'd6 : 16'd2;
      @(negedge clk);
      checks++; if (done !== (c == 12)) begin errors++; $display("[TB] FAIL abort_done c=%0d got %b expected %b", c, done, c == 12); end
      if (c >= 3 && c <= 5) begin
        checks++; if (!axis.tvalid || axis.tdata !== 32'(c - 3)) begin errors++; $display("[TB] FAIL abort_pre_data c=%0d got v=%b d=%0d expected v=1 d=%0d", c, axis.tvalid, axis.tdata, c - 3); end
      end
      if (c == 7) begin
        checks++; if ({axis.tvalid, busy, rd_en} !== 3'b000) begin errors++; $display("[TB] FAIL abort_clear got tvalid=%b busy=%b rd_en=%b expected 0 0 0", axis.tvalid, busy, rd_en); end
      end
      if (c == 8 || c == 9) begin
        checks++; if (!rd_en || rd_addr !== 12'(40 + c - 8)) begin errors++; $display("[TB] FAIL abort_restart_rd c=%0d got en=%b a=%0d expected en=1 a=%0d", c, rd_en, rd_addr, 40 + c - 8); end
      end
      if (c == 10 || c == 11) begin
        checks++;
        if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, c == 11, 32'(40 + c - 10)}) begin
          errors++; $display("[TB] FAIL abort_restart_beat c=%0d got v=%b l=%b d=%0d expected v=1 l=%b d=%0d", c, axis.tvalid, axis.tlast, axis.tdata, c == 11, 40 + c - 10);
        end
      end
      if (c == 12 || c == 13) begin
        checks++; if (busy !== (c == 12)) begin errors++; $display("[TB] FAIL abort_busy c=%0d got %b expected %b", c, busy, c == 12); end
      end
    end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_ignore_start();
    int beats;
    bit done_seen;
    beats = 0; done_seen = 0;
    idle(2);
    for (int c = 0; c < 40 && !done_seen; c++) begin
      next_cycle();
      start = (c == 0) || (c == 4) || (c == 7);
      base_addr = (c == 0) ? 12'd100 : 12'd0;
      num_words = (c == 0) ? 16'd5 : 16'd2;
      @(negedge clk);
      if (axis.tvalid && axis.tready) begin
        checks++; if (axis.tdata !== 32'(100 + beats)) begin errors++; $display("[TB] FAIL ignore_data beat=%0d got %0d expected %0d", beats, axis.tdata, 100 + beats); end
        checks++; if (axis.tlast !== (beats == 4)) begin errors++; $display("[TB] FAIL ignore_tlast beat=%0d got %b expected %b", beats, axis.tlast, beats == 4); end
        beats++;
      end
      if (done) done_seen = 1;
    end
    checks++; if (beats != 5) begin errors++; $display("[TB] FAIL ignore_count got %0d expected 5", beats); end
    checks++; if (!done_seen) begin errors++; $display("[TB] FAIL ignore_done got 0 expected 1"); end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      checks++; if ({busy, axis.tvalid, rd_en} !== 3'b000) begin errors++; $display("[TB] FAIL ignore_after c=%0d got busy=%b tvalid=%b rd_en=%b expected 0 0 0", c, busy, axis.tvalid, rd_en); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_abort();
    test_ignore_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired after %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
